enc_8_to_3_seq: RTL and testbench
=================================

Name: enc_8_to_3_seq

Overview:
- Registered 8-to-3 priority encoder with request capture and a valid/ack handshake. It is the counterpart to dcd_3_to_8.
- Eight request lines are captured into a pending register, either on the rising edge or by level.
- The highest-index unmasked pending request is presented as a stable 3-bit index with valid. The consumer acks it, which clears that request.
- Sits between discrete event/request sources and a consumer that drives dcd_3_to_8 or indexes a table.

Parameters:
- EDGE, 1, 1 = capture on rising edge of in[i]; 0 = capture while in[i] is high (level).
- N, 8, number of request lines; fixed at 8 for this block.
- IW, 3, index width, equal to log2(N).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  8  request lines; synchronous to clk.
- mask  input  8  1 = line i is excluded from selection. It is still captured into pending.
- ack  input  1  consumer accepts the presented index; only meaningful while valid=1.
- out  output  3  encoded index of the granted request; held stable while valid=1.
- valid  output  1  out holds a granted request awaiting ack.
- pending  output  8  current pending request register.

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, in_q=0, state=IDLE, out=0, valid=0. Applies immediately, including mid-handshake.
- Capture: in_q <= in every cycle.
  - set = in & ~in_q when EDGE=1; set = in when EDGE=0.
  - pending <= (pending & ~clr) | set.
- Clear: clr = one-hot(out) when state=BUSY and ack=1; otherwise 0.
  - If set and clr hit the same bit in the same cycle, set wins and the bit stays 1.
  - In level mode, a line still high after ack is therefore re-pended.
- Selection: cand = pending & ~mask. Priority is fixed, highest index first (bit 7 beats bit 0).
- FSM, two states:
  - IDLE: valid=0. If cand != 0 at a clock edge: out <= prio(cand), state <= BUSY. Otherwise stay IDLE and hold out.
  - BUSY: valid=1, out frozen. Changes to mask or new higher-priority requests do not preempt.
  - BUSY with ack=1 at an edge: clear pending[out], state <= IDLE, so valid=0 the next cycle. out keeps its last value.
  - BUSY with ack=0: hold.
- Latency: in rises before edge k, so pending bit is set after edge k. valid=1 with out=i after edge k+1, giving 2 cycles from request to valid.
- Grant spacing: after an ack, valid is low for at least 1 cycle before the next grant.
- ack while IDLE is ignored and clears nothing.
- A masked pending bit stays pending indefinitely. It becomes eligible in the cycle after mask[i] drops.
- A repeat edge on a bit that is already pending merges into the single pending bit. No counting, no overflow flag.
- All outputs are registered; there is no combinational path from in/mask/ack to out or valid.

Decomposition:
- Shared package:
  - state encoding constants ST_IDLE=1'b0, ST_BUSY=1'b1;
  - N=8, IW=3.
- Sub-module prio_enc_8 (combinational): input 8 bits, output 3-bit index of the highest set bit, plus an any-set flag. Instantiated once on cand.

Test Plan:
- Reset then idle: rst_n=0 then 1, in=0 → out=0, valid=0, pending=0 for 10 cycles; ack pulses have no effect.
- Single request, EDGE=1: in=8'h08 from cycle 2.
  - pending=8'h08 after edge 2; valid=1, out=3 after edge 3.
  - ack at edge 5 → valid=0 after edge 5, pending=0.
  - in held high does not re-pend.
- Priority and no preemption: pending 8'h05 → grant out=2.
  - Raise in[7] while BUSY → out stays 2 until ack.
  - Then valid drops for 1 cycle, next grant out=7, then out=0.
- Mask: in=8'h81 with mask=8'h80 → grant out=0 only.
  - pending[7] stays 1.
  - Clear mask → out=7 granted 1 cycle after mask drops, provided the FSM is IDLE.
- Set/clear collision, EDGE=0: in[4] held high, ack the out=4 grant → pending[4] stays 1, and valid re-asserts with out=4 two cycles after ack.
- Async reset mid-handshake: rst_n low while valid=1, out=6 → valid=0, out=0, pending=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/enc_8_to_3_seq_pkg.sv
// Shared constants, state encoding and helpers for the registered 8-to-3 priority encoder.
package enc_8_to_3_seq_pkg;

  localparam int N  = 8;
  localparam int IW = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic [N-1:0] idx_onehot(input logic [IW-1:0] idx);
    idx_onehot = {{(N-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/enc_8_to_3_seq_prio_enc_8.sv
// Combinational 8-input priority encoder: index of the highest set bit plus an any-set flag.
module prio_enc_8
  import enc_8_to_3_seq_pkg::*;
(
  input  logic [N-1:0]  req,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Highest index wins; idx is don't-care (zero) when nothing is set
  always_comb begin
    idx = {IW{1'b0}};
    any = |req;
    casez (req)
      8'b1???????: idx = 3'd7;
      8'b01??????: idx = 3'd6;
      8'b001?????: idx = 3'd5;
      8'b0001????: idx = 3'd4;
      8'b00001???: idx = 3'd3;
      8'b000001??: idx = 3'd2;
      8'b0000001?: idx = 3'd1;
      8'b00000001: idx = 3'd0;
      default:     idx = 3'd0;
    endcase
  end

endmodule

// File: rtl/enc_8_to_3_seq.sv
// Registered 8-to-3 priority encoder with edge/level request capture and valid/ack handshake.
module enc_8_to_3_seq
  import enc_8_to_3_seq_pkg::*;
#(
  parameter int EDGE = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  in,
  input  logic [N-1:0]  mask,
  input  logic          ack,
  output logic [IW-1:0] out,
  output logic          valid,
  output logic [N-1:0]  pending
);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [N-1:0]  in_q_r;
  logic [N-1:0]  pending_r;
  logic [N-1:0]  set_s;
  logic [N-1:0]  clr_s;
  logic [N-1:0]  cand_s;
  logic [IW-1:0] out_r;
  logic [IW-1:0] out_nxt_s;
  logic [IW-1:0] cand_idx_s;
  logic          cand_any_s;
  logic          valid_r;

  assign cand_s = pending_r & ~mask;

  prio_enc_8 u_prio (
    .req (cand_s),
    .idx (cand_idx_s),
    .any (cand_any_s)
  );

  // Request set/clear terms; set is OR-ed in after clear so a collision keeps the bit
  always_comb begin
    set_s = {N{1'b0}};
    clr_s = {N{1'b0}};
    if (EDGE != 0) begin
      set_s = in & ~in_q_r;
    end else begin
      set_s = in;
    end
    if ((state_r == ST_BUSY) && ack) begin
      clr_s = idx_onehot(out_r);
    end else begin
      clr_s = {N{1'b0}};
    end
  end

  // Grant FSM next-state: out only loads on an IDLE->BUSY transition
  always_comb begin
    state_nxt_s = state_r;
    out_nxt_s   = out_r;
    case (state_r)
      ST_IDLE: begin
        if (cand_any_s) begin
          state_nxt_s = ST_BUSY;
          out_nxt_s   = cand_idx_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (ack) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, capture and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      in_q_r    <= {N{1'b0}};
      pending_r <= {N{1'b0}};
      out_r     <= {IW{1'b0}};
      valid_r   <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      in_q_r    <= in;
      pending_r <= (pending_r & ~clr_s) | set_s;
      out_r     <= out_nxt_s;
      valid_r   <= (state_nxt_s == ST_BUSY);
    end
  end

  assign out     = out_r;
  assign valid   = valid_r;
  assign pending = pending_r;

endmodule

// File: tb/tb_enc_8_to_3_seq.sv
// Self-checking bench: edge- and level-mode instances against a cycle-level reference model.
module tb_enc_8_to_3_seq;

  logic       clk;
  logic       rst_n;
  logic [7:0] in;
  logic [7:0] mask;
  logic       ack;
  logic [2:0] out_e, out_l;
  logic       valid_e, valid_l;
  logic [7:0] pend_e, pend_l;

  int n_cmp;
  int n_err;

  // Reference model state, index 0 = edge mode, 1 = level mode
  logic [7:0] m_pend [2];
  logic [7:0] m_inq  [2];
  int         m_out  [2];
  bit         m_busy [2];

  enc_8_to_3_seq #(.EDGE(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .in(in), .mask(mask), .ack(ack),
    .out(out_e), .valid(valid_e), .pending(pend_e)
  );

  enc_8_to_3_seq #(.EDGE(0)) dut_l (
    .clk(clk), .rst_n(rst_n), .in(in), .mask(mask), .ack(ack),
    .out(out_l), .valid(valid_l), .pending(pend_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_pend[m] = 8'h00;
      m_inq[m]  = 8'h00;
      m_out[m]  = 0;
      m_busy[m] = 1'b0;
    end
  endtask

  // One clock edge of the behavioural rules, using pre-edge values
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      logic [7:0] newreq;
      logic [7:0] nxt;
      logic [7:0] elig;
      newreq = 8'h00;
      for (int i = 0; i < 8; i++) begin
        if (in[i] && (m == 1 || !m_inq[m][i])) newreq[i] = 1'b1;
      end
      nxt = m_pend[m];
      if (m_busy[m] && ack) nxt[m_out[m]] = 1'b0;
      nxt  = nxt | newreq;
      elig = m_pend[m] & ~mask;
      if (!m_busy[m]) begin
        for (int i = 7; i >= 0; i--) begin
          if (elig[i] && !m_busy[m]) begin
            m_busy[m] = 1'b1;
            m_out[m]  = i;
          end
        end
      end else if (ack) begin
        m_busy[m] = 1'b0;
      end
      m_pend[m] = nxt;
      m_inq[m]  = in;
    end
  endtask

  task automatic cmp_all();
    chk("out_e",     32'(out_e),   32'(m_out[0]));
    chk("valid_e",   32'(valid_e), 32'(m_busy[0]));
    chk("pending_e", 32'(pend_e),  32'(m_pend[0]));
    chk("out_l",     32'(out_l),   32'(m_out[1]));
    chk("valid_l",   32'(valid_l), 32'(m_busy[1]));
    chk("pending_l", 32'(pend_l),  32'(m_pend[1]));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    cmp_all();
  endtask

  // Asynchronous reset asserted between edges; outputs must clear before any clock edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_out_e",   32'(out_e),   32'd0);
    chk("rst_valid_e", 32'(valid_e), 32'd0);
    chk("rst_pend_e",  32'(pend_e),  32'd0);
    chk("rst_out_l",   32'(out_l),   32'd0);
    chk("rst_valid_l", 32'(valid_l), 32'd0);
    chk("rst_pend_l",  32'(pend_l),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    in    = 8'h00;
    mask  = 8'h00;
    ack   = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #2;
    do_reset();

    // Idle with stray acks
    for (int c = 0; c < 10; c++) begin
      ack = c[0];
      tick();
      chk("idle_valid", 32'(valid_e), 32'd0);
    end
    ack = 1'b0;

    // Single request, edge mode
    do_reset();
    in = 8'h08;
    tick();
    chk("single_pend", 32'(pend_e), 32'h08);
    tick();
    chk("single_valid", 32'(valid_e), 32'd1);
    chk("single_out", 32'(out_e), 32'd3);
    tick();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("single_ackv", 32'(valid_e), 32'd0);
    chk("single_ackp", 32'(pend_e), 32'h00);
    for (int c = 0; c < 3; c++) tick();
    chk("single_norepend", 32'(pend_e), 32'h00);

    // Priority, no preemption
    do_reset();
    in = 8'h05;
    tick();
    tick();
    chk("prio_first", 32'(out_e), 32'd2);
    in = 8'h85;
    tick();
    tick();
    chk("prio_nopreempt", 32'(out_e), 32'd2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("prio_gap", 32'(valid_e), 32'd0);
    tick();
    chk("prio_second", 32'(out_e), 32'd7);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    chk("prio_third", 32'(out_e), 32'd0);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Mask holds bit 7 pending until released
    do_reset();
    mask = 8'h80;
    in   = 8'h81;
    tick();
    tick();
    chk("mask_out", 32'(out_e), 32'd0);
    chk("mask_pend7", 32'(pend_e[7]), 32'd1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    in  = 8'h00;
    tick();
    tick();
    chk("mask_hold", 32'(valid_e), 32'd0);
    mask = 8'h00;
    tick();
    chk("mask_rel_v", 32'(valid_e), 32'd1);
    chk("mask_rel_o", 32'(out_e), 32'd7);
    ack = 1'b1;
    tick();
    ack = 1'b0;

    // Set/clear collision, level mode
    do_reset();
    in = 8'h10;
    tick();
    tick();
    chk("coll_out", 32'(out_l), 32'd4);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("coll_pend", 32'(pend_l[4]), 32'd1);
    chk("coll_gap", 32'(valid_l), 32'd0);
    tick();
    chk("coll_regrant", 32'(valid_l), 32'd1);
    chk("coll_out2", 32'(out_l), 32'd4);

    // Async reset mid-handshake
    do_reset();
    in = 8'h40;
    tick();
    tick();
    chk("mid_valid", 32'(valid_e), 32'd1);
    chk("mid_out", 32'(out_e), 32'd6);
    #2;
    do_reset();
    in = 8'h00;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in   = 8'($urandom);
      mask = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      ack  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
